// File: rtl/sram_col_ctrl.sv
// sram_col_ctrl: sequences one SRAM column through precharge, word-line,
// sense and write phases behind a single-requester req/ready interface.
// All array control lines are decoded from the registered state only, so
// nothing on the array side ever follows req combinationally.
module sram_col_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   ready,
  output logic                   rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   pre_n,
  output logic [2**ADDR_W-1:0]   wl,
  output logic                   sa_en,
  output logic                   wr_en,
  output logic [DATA_W-1:0]      wd,
  input  logic [DATA_W-1:0]      sa_out
);

  localparam int ROWS = 2**ADDR_W;

  // Phase counters are 4 bits wide, so the phase lengths must fit 1..15.
  generate
    if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_pre_cyc
      $error("sram_col_ctrl: PRE_CYC must be in 1..15");
    end
    if (WL_CYC < 1 || WL_CYC > 15) begin : g_bad_wl_cyc
      $error("sram_col_ctrl: WL_CYC must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECH   = 3'd1,
    ACCESS  = 3'd2,
    SENSE   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wd_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                accept;
  logic                wl_on;

  // Only an idle controller takes a request; req while busy is dropped.
  assign accept = (state_reg == IDLE) && req;

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    pre_n      = 1'b1;
    wl_on      = 1'b0;
    sa_en      = 1'b0;
    wr_en      = 1'b0;
    rvalid     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        pre_n = 1'b0;
        if (req) begin
          state_next = PRECH;
          cnt_next   = 4'(PRE_CYC - 1);
        end
      end
      PRECH: begin
        // Full precharge is always served, even straight after a previous access.
        pre_n = 1'b0;
        if (cnt_reg == 4'd0) begin
          state_next = ACCESS;
          cnt_next   = 4'(WL_CYC - 1);
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACCESS: begin
        wl_on = 1'b1;
        wr_en = we_reg;
        if (cnt_reg == 4'd0) begin
          state_next = we_reg ? RECOVER : SENSE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      SENSE: begin
        wl_on      = 1'b1;
        sa_en      = 1'b1;
        state_next = RECOVER;
      end
      RECOVER: begin
        // Word line is already off here, so precharge can resume next cycle.
        rvalid     = ~we_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Request capture on the accepting edge and read data capture on SENSE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        we_reg   <= we;
        addr_reg <= addr;
        wd_reg   <= wdata;
      end
      if (state_reg == SENSE) begin
        rdata_reg <= sa_out;
      end
    end
  end

  // One-hot word-line decode from the latched row address.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_wl
      assign wl[gi] = wl_on && (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  assign wd    = wd_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_sram_col_ctrl.sv
// tb_sram_col_ctrl: directed bench for sram_col_ctrl with a small bit-cell
// array model behind the write drivers and sense amps.
module tb_sram_col_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        pre_n;
  logic [15:0] wl;
  logic        sa_en;
  logic        wr_en;
  logic [7:0]  wd;
  logic [7:0]  sa_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Array model: preload port for the bench, write drivers from the DUT.
  logic [7:0]  mem [16];
  logic        preload;
  logic [3:0]  pre_addr;
  logic [7:0]  pre_data;

  always #5 clk = ~clk;

  sram_col_ctrl #(
    .ADDR_W(4), .DATA_W(8), .PRE_CYC(2), .WL_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata),
    .pre_n(pre_n), .wl(wl), .sa_en(sa_en), .wr_en(wr_en), .wd(wd),
    .sa_out(sa_out)
  );

  always @(posedge clk) begin
    if (preload) mem[pre_addr] <= pre_data;
    else if (wr_en) begin
      for (int i = 0; i < 16; i++) if (wl[i]) mem[i] <= wd;
    end
  end

  always_comb begin
    sa_out = 8'h00;
    if (sa_en) begin
      for (int i = 0; i < 16; i++) if (wl[i]) sa_out = mem[i];
    end
  end

  // Array-safety invariants, checked mid-cycle.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      n_cmp += 4;
      if (!pre_n && wl != 16'h0) begin
        n_bad++; $display("FAIL inv_pre_wl pre_n=%b wl=%h", pre_n, wl);
      end
      if (sa_en && wr_en) begin
        n_bad++; $display("FAIL inv_sa_wr sa_en=%b wr_en=%b", sa_en, wr_en);
      end
      if ((wl & (wl - 16'd1)) != 16'h0) begin
        n_bad++; $display("FAIL inv_onehot wl=%h", wl);
      end
      if (ready && (pre_n || wl != 16'h0 || sa_en || wr_en || rvalid)) begin
        n_bad++; $display("FAIL inv_ready_idle pre_n=%b wl=%h sa=%b wr=%b rv=%b",
                          pre_n, wl, sa_en, wr_en, rvalid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    preload = 1'b1; pre_addr = a; pre_data = d;
    tick();
    preload = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'd0;
    preload = 1'b0; pre_addr = 4'd0; pre_data = 8'd0;
    repeat (3) tick();
    obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
    n_cmp++;
    if (obs !== {5'b10000, 16'h0}) begin
      n_bad++; $display("FAIL reset_held got %h want %h", obs, {5'b10000, 16'h0});
    end
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
      n_cmp++;
      if (obs !== {5'b10000, 16'h0}) begin
        n_bad++; $display("FAIL reset_idle%0d got %h want %h", k, obs, {5'b10000, 16'h0});
      end
    end
    n_cmp++;
    if (rdata !== 8'h00 || wd !== 8'h00) begin
      n_bad++; $display("FAIL reset_data rdata=%h wd=%h want 00 00", rdata, wd);
    end
    $display("reset: released and idle 5 cycles");
  endtask

  task automatic test_write();
    logic [20:0] obs, exp;
    req = 1'b1; we = 1'b1; addr = 4'd3; wdata = 8'hA5;
    tick();
    req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      case (k)
        1, 2:    exp = {5'b00000, 16'h0000};
        3, 4:    exp = {5'b01010, 16'h0008};
        5:       exp = {5'b01000, 16'h0000};
        default: exp = {5'b10000, 16'h0000};
      endcase
      obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL write_cyc%0d got %h want %h", k, obs, exp);
      end
      if (k == 3 || k == 4) begin
        n_cmp++;
        if (wd !== 8'hA5) begin
          n_bad++; $display("FAIL write_wd%0d got %h want a5", k, wd);
        end
      end
      if (k < 6) tick();
    end
    n_cmp++;
    if (rdata !== 8'h00) begin
      n_bad++; $display("FAIL write_rdata got %h want 00", rdata);
    end
    $display("write: addr=3 wdata=a5 done");
  endtask

  task automatic test_read_top();
    logic [20:0] obs, exp;
    load(4'd15, 8'h3C);
    req = 1'b1; we = 1'b0; addr = 4'd15; wdata = 8'h00;
    tick();
    req = 1'b0; addr = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      case (k)
        1, 2:    exp = {5'b00000, 16'h0000};
        3, 4:    exp = {5'b01000, 16'h8000};
        5:       exp = {5'b01100, 16'h8000};
        6:       exp = {5'b01001, 16'h0000};
        default: exp = {5'b10000, 16'h0000};
      endcase
      obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL read15_cyc%0d got %h want %h", k, obs, exp);
      end
      if (k >= 6) begin
        n_cmp++;
        if (rdata !== 8'h3C) begin
          n_bad++; $display("FAIL read15_rdata%0d got %h want 3c", k, rdata);
        end
      end
      if (k < 8) tick();
    end
    $display("read: addr=15 rdata=%h", rdata);
  endtask

  task automatic test_back_to_back();
    logic [20:0] obs, exp;
    load(4'd1, 8'h5A);
    req = 1'b1; we = 1'b0; addr = 4'd1; wdata = 8'h00;
    tick();
    we = 1'b1; addr = 4'd2; wdata = 8'h77;
    for (int k = 1; k <= 14; k++) begin
      case (k)
        1, 2:    exp = {5'b00000, 16'h0000};
        3, 4:    exp = {5'b01000, 16'h0002};
        5:       exp = {5'b01100, 16'h0002};
        6:       exp = {5'b01001, 16'h0000};
        7:       exp = {5'b10000, 16'h0000};
        8, 9:    exp = {5'b00000, 16'h0000};
        10, 11:  exp = {5'b01010, 16'h0004};
        12:      exp = {5'b01000, 16'h0000};
        default: exp = {5'b10000, 16'h0000};
      endcase
      obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL b2b_cyc%0d got %h want %h", k, obs, exp);
      end
      if (k >= 6) begin
        n_cmp++;
        if (rdata !== 8'h5A) begin
          n_bad++; $display("FAIL b2b_rdata%0d got %h want 5a", k, rdata);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (wd !== 8'h77) begin
          n_bad++; $display("FAIL b2b_wd got %h want 77", wd);
        end
      end
      if (k == 8) begin
        req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'h00;
      end
      if (k < 14) tick();
    end
    $display("back_to_back: read addr=1 then write addr=2");
  endtask

  task automatic test_ignored_req();
    logic [20:0] obs, exp;
    req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h11;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      case (k)
        1, 2:    exp = {5'b00000, 16'h0000};
        3, 4:    exp = {5'b01010, 16'h0020};
        5:       exp = {5'b01000, 16'h0000};
        default: exp = {5'b10000, 16'h0000};
      endcase
      obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL ignore_cyc%0d got %h want %h", k, obs, exp);
      end
      if (k == 3 || k == 4) begin
        n_cmp++;
        if (wd !== 8'h11) begin
          n_bad++; $display("FAIL ignore_wd%0d got %h want 11", k, wd);
        end
      end
      if (k == 2) begin
        req = 1'b1; we = 1'b0; addr = 4'd9; wdata = 8'hFF;
      end else if (k == 3) begin
        req = 1'b0; addr = 4'd12; wdata = 8'h00;
      end
      if (k < 8) tick();
    end
    $display("ignored_req: busy req dropped, write addr=5 kept 11");
  endtask

  task automatic test_reset_mid_access();
    logic [20:0] obs;
    load(4'd7, 8'hC3);
    req = 1'b1; we = 1'b0; addr = 4'd7; wdata = 8'h00;
    tick();
    req = 1'b0; addr = 4'd0;
    tick(); tick();
    obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
    n_cmp++;
    if (obs !== {5'b01000, 16'h0080}) begin
      n_bad++; $display("FAIL rstmid_access got %h want %h", obs, {5'b01000, 16'h0080});
    end
    rst_n = 1'b0;
    #1;
    obs = {ready, pre_n, sa_en, wr_en, rvalid, wl};
    n_cmp++;
    if (obs !== {5'b10000, 16'h0000}) begin
      n_bad++; $display("FAIL rstmid_async got %h want %h", obs, {5'b10000, 16'h0000});
    end
    n_cmp++;
    if (rdata !== 8'h00 || wd !== 8'h00) begin
      n_bad++; $display("FAIL rstmid_data rdata=%h wd=%h want 00 00", rdata, wd);
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (rvalid !== 1'b0 || ready !== 1'b1) begin
        n_bad++; $display("FAIL rstmid_idle%0d rvalid=%b ready=%b want 0 1", k, rvalid, ready);
      end
    end
    $display("reset_mid_access: read addr=7 abandoned");
  endtask

  task automatic test_readback(input logic [3:0] a, input logic [7:0] d);
    req = 1'b1; we = 1'b0; addr = a; wdata = 8'h00;
    tick();
    req = 1'b0; addr = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (rvalid !== 1'b0) begin
        n_bad++; $display("FAIL readback%0d_early_rvalid cyc%0d got 1 want 0", a, k);
      end
      tick();
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== d) begin
      n_bad++; $display("FAIL readback%0d rvalid=%b rdata=%h want 1 %h", a, rvalid, rdata, d);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1 || rvalid !== 1'b0) begin
      n_bad++; $display("FAIL readback%0d_end ready=%b rvalid=%b want 1 0", a, ready, rvalid);
    end
    $display("readback: addr=%0d rdata=%h", a, rdata);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_top();
    test_back_to_back();
    test_ignored_req();
    test_reset_mid_access();
    test_readback(4'd3, 8'hA5);
    test_readback(4'd5, 8'h11);
    test_readback(4'd2, 8'h77);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_col_ctrl.md
Name: sram_col_ctrl

Overview:
- Sequences one column of 6T bit cells (complementary BL/BLB pair per bit) through precharge, word-line, sense and write phases.
- Presents a single-requester req/ready interface to the system side.
- Drives the precharge devices, one-hot word lines, sense-amp enable and write drivers for the array.
- Is the only block allowed to toggle array control lines; the array itself stays pure bit cells and bitlines.

Parameters:
- ADDR_W, 4, word-line address width; the array has 2**ADDR_W rows.
- DATA_W, 8, bits per word (number of BL/BLB pairs).
- PRE_CYC, 2, precharge cycles per access; legal range 1..15.
- WL_CYC, 2, word-line-on cycles before sense or write completion; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  access request.
- we  input  1  1=write, 0=read; sampled with req.
- addr  input  ADDR_W  row address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- ready  output  1  controller idle and able to accept req.
- rvalid  output  1  one-cycle pulse; rdata valid.
- rdata  output  DATA_W  last read word.
- pre_n  output  1  bitline precharge/equalise enable, active-low.
- wl  output  2**ADDR_W  one-hot word lines, active-high.
- sa_en  output  1  sense-amp enable.
- wr_en  output  1  write-driver enable; drivers force BL=wd, BLB=~wd.
- wd  output  DATA_W  write-driver data (latched wdata).
- sa_out  input  DATA_W  sense-amp outputs; valid while sa_en=1.

Behaviour:
- Reset: ready=1, rvalid=0, rdata=0, pre_n=0 (bitlines precharging), wl=0, sa_en=0, wr_en=0, wd=0, state=IDLE, counter=0.
  - Reset is asynchronous and may arrive mid-access; all outputs return to reset values immediately.
  - Any in-flight access is abandoned with no rvalid.
- States: IDLE, PRECH, ACCESS, SENSE, RECOVER. Outputs are decoded from the registered state (Moore), with no combinational path from req.
- IDLE:
  - ready=1, pre_n=0, all enables 0.
  - req=1 is the accepting edge: latch we/addr/wdata (wd<=wdata), go to PRECH, load counter with PRE_CYC-1.
- PRECH:
  - pre_n=0, wl=0, ready=0.
  - Decrement counter; at 0, go to ACCESS with counter=WL_CYC-1.
  - Guarantees a full PRE_CYC precharge even on back-to-back accesses.
- ACCESS:
  - pre_n=1, wl[addr_latched]=1 (exactly one bit), wr_en=we_latched.
  - At counter 0: read goes to SENSE; write goes to RECOVER.
- SENSE (reads only, 1 cycle):
  - pre_n=1, wl held, sa_en=1.
  - At the exit edge, rdata<=sa_out; go to RECOVER.
- RECOVER (1 cycle):
  - wl=0, sa_en=0, wr_en=0, pre_n=1.
  - rvalid=1 only if the access was a read.
  - Then go to IDLE; precharge resumes.
- Latency with defaults, counting N edges after the accepting edge:
  - Read: PRECH 1-2, ACCESS 3-4, SENSE 5, RECOVER 6 (rvalid=1), ready=1 at 7.
  - Write: PRECH 1-2, ACCESS 3-4, RECOVER 5, ready=1 at 6.
  - General read cycle = PRE_CYC+WL_CYC+3; write = PRE_CYC+WL_CYC+2.
- Invariants (assert in bench):
  - Never pre_n=0 together with any wl bit set.
  - Never sa_en and wr_en both set.
  - wl is zero or one-hot.
  - ready=1 only in IDLE.
- req while ready=0 is ignored (not queued).
- Inputs changing after acceptance have no effect on the access.
- rdata holds its value until the next read's SENSE exit; writes do not alter it.
- Address wrap: addr=2**ADDR_W-1 selects the top word line. No out-of-range case exists.
- Counter is 4 bits wide; PRE_CYC or WL_CYC outside 1..15 is illegal (elaboration-time check).

Test Plan:
- Reset, then hold idle 5 cycles -> ready=1, pre_n=0, wl=0, sa_en=0, wr_en=0, rdata=0.
- Write addr=3, wdata=0xA5 -> pre_n=0 for 2 cycles; then wl=0x0008 with wr_en=1 and wd=0xA5 for 2 cycles; no sa_en; no rvalid; ready=1 six edges after accept.
- Read addr=15 with sa_out model returning 0x3C -> sa_en=1 in cycle 5 only, wl=0x8000 in cycles 3-5, rvalid=1 in cycle 6 only, rdata=0x3C held after.
- Back-to-back: req held high for read addr=1, then write addr=2 -> second accept exactly on the first ready=1 edge; second access still gets 2 full precharge cycles; wl never overlaps pre_n=0.
- req pulsed and addr/wdata changed during a busy access -> ignored; the in-flight access uses the latched values.
- Assert rst_n=0 mid-ACCESS of a read -> same cycle: wl=0, pre_n=0, ready=1, no rvalid ever; the next read completes normally.
